// File: rtl/reset_seq_pkg.sv
// ============================================================
// reset_seq_pkg : shared types and constants for reset_seq
// Rev 1.0
// ============================================================
`default_nettype none

package reset_seq_pkg;

  localparam int CAUSE_W    = 5;
  localparam int CAUSE_POR  = 0;
  localparam int CAUSE_LOCK = 1;
  localparam int CAUSE_BTN  = 2;
  localparam int CAUSE_SW   = 3;
  localparam int CAUSE_WD   = 4;

  localparam logic [CAUSE_W-1:0] CAUSE_RESET_VAL = 5'b00001;

  typedef enum logic [2:0] {
    HOLD      = 3'd0,
    WAIT_LOCK = 3'd1,
    REL_MEM   = 3'd2,
    REL_SYS   = 3'd3,
    RUN       = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/reset_seq_sync_ff.sv
// ============================================================
// sync_ff : SYNC_STAGES-deep single-bit synchroniser, async reset to 0
// Rev 1.0
// ============================================================
`default_nettype none

module sync_ff #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] r_stages;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_stages <= '0;
    else     r_stages <= {r_stages[SYNC_STAGES-2:0], d};
  end

  assign q = r_stages[SYNC_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/reset_seq.sv
// ============================================================
// reset_seq : staged memory/system reset sequencer with cause log
// Rev 1.0
// ============================================================
`default_nettype none

module reset_seq
  import reset_seq_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int HOLD_CYCLES   = 16,
  parameter int STAGE_GAP     = 8,
  parameter int DEBOUNCE_BITS = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clk_ok,
  input  logic               btn_rst_n,
  input  logic               sw_rst,
  input  logic               wd_rst,
  output logic               rst_mem,
  output logic               rst_sys,
  output logic               seq_done,
  output logic [CAUSE_W-1:0] rst_cause
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int GAP_W  = $clog2(STAGE_GAP + 1);
  localparam logic [HOLD_W-1:0]        HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [GAP_W-1:0]         GAP_LAST  = GAP_W'(STAGE_GAP - 1);
  localparam logic [DEBOUNCE_BITS-1:0] DEB_LAST  = {{(DEBOUNCE_BITS-1){1'b1}}, 1'b0};

  logic lock_sync;
  logic btn_n_sync;

  sync_ff #(.SYNC_STAGES(SYNC_STAGES)) u_sync_lock (
    .clk (clk),
    .rst (rst),
    .d   (clk_ok),
    .q   (lock_sync)
  );

  sync_ff #(.SYNC_STAGES(SYNC_STAGES)) u_sync_btn (
    .clk (clk),
    .rst (rst),
    .d   (btn_rst_n),
    .q   (btn_n_sync)
  );

  // Debounce: the state flips on the (2^DEBOUNCE_BITS-1)th consecutive differing cycle
  logic [DEBOUNCE_BITS-1:0] deb_cnt;
  logic                     btn_pressed;
  logic                     deb_differ;
  logic                     deb_flip;
  logic                     press;

  assign deb_differ = (~btn_n_sync) != btn_pressed;
  assign deb_flip   = deb_differ && (deb_cnt == DEB_LAST);
  assign press      = deb_flip && !btn_pressed;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_cnt     <= '0;
      btn_pressed <= 1'b0;
    end else if (!deb_differ) begin
      deb_cnt     <= '0;
    end else if (deb_flip) begin
      deb_cnt     <= '0;
      btn_pressed <= ~btn_pressed;
    end else begin
      deb_cnt     <= deb_cnt + DEBOUNCE_BITS'(1);
    end
  end

  state_t               state, state_nxt;
  logic [HOLD_W-1:0]    hold_cnt, hold_nxt;
  logic [GAP_W-1:0]     gap_cnt, gap_nxt;
  logic [CAUSE_W-1:0]   cause_nxt;
  logic [CAUSE_W-1:0]   ev_bits;
  logic                 any_ev;
  logic                 mem_nxt, sys_nxt, done_nxt;

  // Lock loss only matters once the memory controller has been released
  always_comb begin
    ev_bits             = '0;
    ev_bits[CAUSE_LOCK] = !lock_sync && (state == REL_MEM || state == REL_SYS || state == RUN);
    ev_bits[CAUSE_BTN]  = press;
    ev_bits[CAUSE_SW]   = sw_rst;
    ev_bits[CAUSE_WD]   = wd_rst;
  end

  assign any_ev = |ev_bits;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= HOLD;
      hold_cnt  <= '0;
      gap_cnt   <= '0;
      rst_cause <= CAUSE_RESET_VAL;
      rst_mem   <= 1'b1;
      rst_sys   <= 1'b1;
      seq_done  <= 1'b0;
    end else begin
      state     <= state_nxt;
      hold_cnt  <= hold_nxt;
      gap_cnt   <= gap_nxt;
      rst_cause <= cause_nxt;
      rst_mem   <= mem_nxt;
      rst_sys   <= sys_nxt;
      seq_done  <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    gap_nxt   = gap_cnt;
    cause_nxt = rst_cause;
    if (any_ev) begin
      state_nxt = HOLD;
      hold_nxt  = '0;
      gap_nxt   = '0;
      cause_nxt = (state == RUN) ? ev_bits : (rst_cause | ev_bits);
    end else begin
      case (state)
        HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            state_nxt = WAIT_LOCK;
            hold_nxt  = '0;
          end else begin
            hold_nxt  = hold_cnt + HOLD_W'(1);
          end
        end
        WAIT_LOCK: begin
          if (lock_sync && !btn_pressed) begin
            state_nxt = REL_MEM;
            gap_nxt   = '0;
          end
        end
        REL_MEM: begin
          if (gap_cnt == GAP_LAST) begin
            state_nxt = RUN;
            gap_nxt   = '0;
          end else begin
            gap_nxt   = gap_cnt + GAP_W'(1);
          end
        end
        REL_SYS: state_nxt = RUN;
        RUN:     state_nxt = RUN;
        default: state_nxt = HOLD;
      endcase
    end
  end

  // Outputs are decoded from the next state so they change on the same edge
  always_comb begin
    mem_nxt  = (state_nxt == HOLD) || (state_nxt == WAIT_LOCK);
    sys_nxt  = (state_nxt != RUN);
    done_nxt = (state_nxt == RUN);
  end

endmodule

`default_nettype wire

// File: tb/tb_reset_seq.sv
// ============================================================
// tb_reset_seq : directed stimulus with cycle-level reference model
// Rev 1.0
// ============================================================
`default_nettype none

module tb_reset_seq;

  localparam int SYNC_STAGES   = 2;
  localparam int HOLD_CYCLES   = 16;
  localparam int STAGE_GAP     = 8;
  localparam int DEBOUNCE_BITS = 4;

  logic       clk       = 1'b0;
  logic       rst       = 1'b1;
  logic       clk_ok    = 1'b1;
  logic       btn_rst_n = 1'b1;
  logic       sw_rst    = 1'b0;
  logic       wd_rst    = 1'b0;
  logic       rst_mem;
  logic       rst_sys;
  logic       seq_done;
  logic [4:0] rst_cause;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  reset_seq #(
    .SYNC_STAGES   (SYNC_STAGES),
    .HOLD_CYCLES   (HOLD_CYCLES),
    .STAGE_GAP     (STAGE_GAP),
    .DEBOUNCE_BITS (DEBOUNCE_BITS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .clk_ok    (clk_ok),
    .btn_rst_n (btn_rst_n),
    .sw_rst    (sw_rst),
    .wd_rst    (wd_rst),
    .rst_mem   (rst_mem),
    .rst_sys   (rst_sys),
    .seq_done  (seq_done),
    .rst_cause (rst_cause)
  );

  // Reference model: time since last event and since memory release
  bit         m_mem, m_sys, m_done, m_pressed;
  logic [4:0] m_cause;
  int         m_age, m_gap, m_dcnt;
  bit         lock_q[$];
  bit         btn_q[$];

  task automatic model_reset();
    m_mem = 1; m_sys = 1; m_done = 0; m_cause = 5'b00001;
    m_age = 0; m_gap = 0; m_dcnt = 0; m_pressed = 0;
    lock_q = {};
    btn_q  = {};
    for (int i = 0; i < SYNC_STAGES; i++) begin
      lock_q.push_back(1'b0);
      btn_q.push_back(1'b0);
    end
  endtask

  task automatic model_edge();
    bit         lock_s, raw_pressed, was_pressed, press;
    logic [4:0] ev;
    lock_s      = lock_q[0];
    raw_pressed = !btn_q[0];
    was_pressed = m_pressed;
    press       = 0;
    if (raw_pressed != m_pressed) begin
      m_dcnt++;
      if (m_dcnt == (1 << DEBOUNCE_BITS) - 1) begin
        press     = !m_pressed;
        m_pressed = !m_pressed;
        m_dcnt    = 0;
      end
    end else begin
      m_dcnt = 0;
    end
    ev = {wd_rst, sw_rst, press, (!lock_s && !m_mem), 1'b0};
    if (ev != 5'b0) begin
      m_cause = m_done ? ev : (m_cause | ev);
      m_mem = 1; m_sys = 1; m_done = 0; m_age = 0;
    end else if (m_mem) begin
      if (m_age < HOLD_CYCLES) m_age++;
      else if (lock_s && !was_pressed) begin
        m_mem = 0;
        m_gap = 0;
      end
    end else if (m_sys) begin
      m_gap++;
      if (m_gap == STAGE_GAP) begin
        m_sys  = 0;
        m_done = 1;
      end
    end
    void'(lock_q.pop_front());
    lock_q.push_back(clk_ok);
    void'(btn_q.pop_front());
    btn_q.push_back(btn_rst_n);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else     model_edge();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        n_tests++;
        if ({rst_mem, rst_sys, seq_done, rst_cause} !== {m_mem, m_sys, m_done, m_cause}) begin
          n_fail++;
          $display("FAIL model_cmp t=%0t got mem=%b sys=%b done=%b cause=%b exp mem=%b sys=%b done=%b cause=%b",
                   $time, rst_mem, rst_sys, seq_done, rst_cause, m_mem, m_sys, m_done, m_cause);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Power-on sequence
    tick(16); check("por_mem_e16", rst_mem, 1);
    tick(1);  check("por_mem_e17", rst_mem, 0); check("por_sys_e17", rst_sys, 1);
    tick(7);  check("por_sys_e24", rst_sys, 1); check("por_done_e24", seq_done, 0);
    tick(1);  check("por_sys_e25", rst_sys, 0); check("por_done_e25", seq_done, 1);
    check("por_cause", rst_cause, 5'b00001);

    // Software reset from RUN
    tick(3); sw_rst = 1'b1; tick(1); sw_rst = 1'b0;
    check("sw_mem", rst_mem, 1); check("sw_sys", rst_sys, 1); check("sw_done", seq_done, 0);
    check("sw_cause", rst_cause, 5'b01000);
    tick(16); check("sw_mem_hold", rst_mem, 1);
    tick(1);  check("sw_mem_rel", rst_mem, 0);
    tick(8);  check("sw_sys_rel", rst_sys, 0); check("sw_done_rel", seq_done, 1);

    // Lock loss in RUN
    tick(2); clk_ok = 1'b0;
    tick(2);  check("lock_mem_d2", rst_mem, 0);
    tick(1);  check("lock_mem_d3", rst_mem, 1); check("lock_sys_d3", rst_sys, 1);
    check("lock_cause", rst_cause, 5'b00010);
    tick(37); check("lock_wait", rst_mem, 1);
    clk_ok = 1'b1;
    tick(2);  check("lock_mem_r2", rst_mem, 1);
    tick(1);  check("lock_mem_r3", rst_mem, 0);
    tick(8);  check("lock_done", seq_done, 1); check("lock_cause_keep", rst_cause, 5'b00010);

    // Button glitch then real press
    tick(2); btn_rst_n = 1'b0; tick(10); btn_rst_n = 1'b1;
    tick(20); check("glitch_sys", rst_sys, 0); check("glitch_done", seq_done, 1);
    btn_rst_n = 1'b0;
    tick(16); check("btn_sys_p16", rst_sys, 0);
    tick(1);  check("btn_mem_p17", rst_mem, 1); check("btn_sys_p17", rst_sys, 1);
    check("btn_cause", rst_cause, 5'b00100);
    tick(23); btn_rst_n = 1'b1; check("btn_held", rst_mem, 1);
    tick(17); check("btn_mem_p57", rst_mem, 1);
    tick(1);  check("btn_mem_p58", rst_mem, 0);
    tick(8);  check("btn_done", seq_done, 1);

    // Simultaneous sw+wd, then wd restarts hold
    tick(2); sw_rst = 1'b1; wd_rst = 1'b1; tick(1); sw_rst = 1'b0; wd_rst = 1'b0;
    check("both_cause", rst_cause, 5'b11000); check("both_mem", rst_mem, 1);
    tick(10); wd_rst = 1'b1; tick(1); wd_rst = 1'b0;
    check("wd_hold_cause", rst_cause, 5'b11000);
    tick(16); check("wd_mem_h16", rst_mem, 1);
    tick(1);  check("wd_mem_h17", rst_mem, 0); check("wd_cause_keep", rst_cause, 5'b11000);

    // Async reset in REL_MEM
    tick(3); check("relmem_mem", rst_mem, 0); check("relmem_sys", rst_sys, 1);
    #2 rst = 1'b1;
    #1;
    check("async_mem", rst_mem, 1); check("async_sys", rst_sys, 1);
    check("async_done", seq_done, 0); check("async_cause", rst_cause, 5'b00001);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    tick(16); check("rerun_mem_e16", rst_mem, 1);
    tick(1);  check("rerun_mem_e17", rst_mem, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
